// File: rtl/spi_pkg.sv
// Encodings and widths shared by the SPI master blocks: the baud generator,
// the slave-select generator and the shift register.
package spi_pkg;

  localparam int DIV_W = 12;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  localparam logic [DIV_W-1:0] DIV_RESET = 12'd2;

  // Baud divisor = (SPPR+1) * 2^(SPR+1). The result stays within 2..2048.
  function automatic logic [DIV_W-1:0] calc_divisor(input logic [2:0] sppr,
                                                    input logic [2:0] spr);
    logic [DIV_W-1:0] base;
    logic [3:0]       sh;
    base = DIV_W'(sppr) + DIV_W'(1);
    sh   = {1'b0, spr} + 4'd1;
    return base << sh;
  endfunction

endpackage

// File: rtl/spi_baud_generator_if.sv
// Link between the baud generator and its SPI neighbours: slave select and
// clock configuration in, serial clock and edge strobes out.
interface spi_baud_generator_if;

  // No valid/ready here: ss_i is a level that qualifies the transfer, and the
  // two strobes are single-PCLK, unacknowledged pulses.
  logic ss_i;
  logic cpol_i;
  logic cpha_i;
  logic sclk_o;
  logic sample_pulse_o;
  logic shift_pulse_o;

  modport master (
    input  ss_i,
    input  cpol_i,
    input  cpha_i,
    output sclk_o,
    output sample_pulse_o,
    output shift_pulse_o
  );

  modport slave (
    output ss_i,
    output cpol_i,
    output cpha_i,
    input  sclk_o,
    input  sample_pulse_o,
    input  shift_pulse_o
  );

endinterface

// File: rtl/spi_baud_generator.sv
// Baud divisor capture and SCLK generation for the APB SPI master, with
// one-PCLK strobes that mark the PCLK just before each sample or shift edge.
module spi_baud_generator
  import spi_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [1:0]       spi_mode_i,
  input  logic             spiswai_i,
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  output logic [DIV_W-1:0] BaudRateDivisor_o,
  spi_baud_generator_if.master spi
);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] count_r;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] half_m1;
  logic             sclk_r;
  logic             enable;
  logic             edge_next;
  logic             leading;

  // Must qualify exactly like the slave-select generator does.
  assign enable = !spi.ss_i && !spiswai_i &&
                  ((spi_mode_i == SPI_RUN) || (spi_mode_i == SPI_WAIT));

  assign half    = div_r >> 1;
  assign half_m1 = half - DIV_W'(1);

  // The divisor only tracks the prescaler fields between transfers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      div_r   <= DIV_RESET;
      count_r <= '0;
      sclk_r  <= 1'b0;
    end else if (!enable) begin
      div_r   <= calc_divisor(sppr_i, spr_i);
      count_r <= '0;
      sclk_r  <= spi.cpol_i;
    end else if (count_r == half_m1) begin
      count_r <= '0;
      sclk_r  <= ~sclk_r;
    end else begin
      count_r <= count_r + DIV_W'(1);
    end
  end

  // Strobes are decoded from registered state; gating with enable makes them
  // drop in the same cycle that ss_i rises or the mode leaves run/wait.
  always_comb begin
    edge_next          = 1'b0;
    leading            = 1'b0;
    spi.sample_pulse_o = 1'b0;
    spi.shift_pulse_o  = 1'b0;
    if (!PRESET) begin
      edge_next          = enable && (count_r == half_m1);
      leading            = (sclk_r == spi.cpol_i);
      spi.sample_pulse_o = edge_next &&  (leading ^ spi.cpha_i);
      spi.shift_pulse_o  = edge_next && !(leading ^ spi.cpha_i);
    end
  end

  assign spi.sclk_o        = sclk_r;
  assign BaudRateDivisor_o = div_r;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: divisor capture, SCLK/strobe timing
// in several CPOL/CPHA and divisor settings, stalls, freeze and reset.
module tb_spi_baud_generator;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic [11:0] BaudRateDivisor_o;

  spi_baud_generator_if sif ();

  spi_baud_generator dut (
    .PCLK              (PCLK),
    .PRESET            (PRESET),
    .spi_mode_i        (spi_mode_i),
    .spiswai_i         (spiswai_i),
    .sppr_i            (sppr_i),
    .spr_i             (spr_i),
    .BaudRateDivisor_o (BaudRateDivisor_o),
    .spi               (sif.master)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total;
  int bad;
  logic [2:0] exp_q[$];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected {sclk, sample, shift} k PCLKs after enable rose, half-period h.
  function automatic logic [2:0] model(input int k, input int h, input logic cpol,
                                       input logic cpha);
    int   ph;
    logic sc;
    logic edg;
    logic lead;
    ph   = (k / h) % 2;
    sc   = cpol ^ (ph != 0);
    edg  = (k % h) == (h - 1);
    lead = (ph == 0);
    return {sc, edg && (lead ^ cpha), edg && !(lead ^ cpha)};
  endfunction

  // Pushes the expected output for each active cycle, then pops and compares.
  task automatic run_active(input string tag, input int n, input int h);
    logic [2:0] e;
    logic [2:0] o;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model(k, h, sif.cpol_i, sif.cpha_i));
      e = exp_q.pop_front();
      o = {sif.sclk_o, sif.sample_pulse_o, sif.shift_pulse_o};
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s k=%0d observed={sclk,smp,shf}=%b expected=%b", tag, k, o, e);
      end
      tick();
    end
  endtask

  task automatic chk_idle(input string tag, input logic sclk_exp);
    chk({tag, "_sclk"}, {11'd0, sif.sclk_o}, {11'd0, sclk_exp});
    chk({tag, "_strobes"}, {10'd0, sif.sample_pulse_o, sif.shift_pulse_o}, 12'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    PRESET     = 1'b1;
    spi_mode_i = 2'b00;
    spiswai_i  = 1'b0;
    sppr_i     = 3'd1;
    spr_i      = 3'd0;
    sif.ss_i   = 1'b1;
    sif.cpol_i = 1'b0;
    sif.cpha_i = 1'b0;
    tick();
    tick();
    chk("reset_div", BaudRateDivisor_o, 12'd2);
    chk_idle("reset", 1'b0);

    // divisor capture
    PRESET = 1'b0;
    tick();
    chk("div_1_0", BaudRateDivisor_o, 12'd4);
    sppr_i = 3'd7;
    spr_i  = 3'd7;
    tick();
    chk("div_7_7", BaudRateDivisor_o, 12'd2048);
    sppr_i = 3'd2;
    spr_i  = 3'd1;
    tick();
    chk("div_2_1", BaudRateDivisor_o, 12'd12);

    // mode 0, divisor 4
    sppr_i = 3'd1;
    spr_i  = 3'd0;
    tick();
    chk("div_mode0", BaudRateDivisor_o, 12'd4);
    sif.ss_i = 1'b0;
    #1;
    run_active("mode0", 8, 2);
    sif.ss_i = 1'b1;
    #1;
    chk("mode0_drop_strobes", {10'd0, sif.sample_pulse_o, sif.shift_pulse_o}, 12'd0);
    tick();
    chk_idle("mode0_end", 1'b0);

    // mode 3, divisor 8
    sif.cpol_i = 1'b1;
    sif.cpha_i = 1'b1;
    sppr_i     = 3'd3;
    spr_i      = 3'd0;
    tick();
    chk("div_mode3", BaudRateDivisor_o, 12'd8);
    chk_idle("mode3_idle", 1'b1);
    sif.ss_i = 1'b0;
    #1;
    run_active("mode3", 12, 4);
    sif.ss_i = 1'b1;
    tick();
    chk_idle("mode3_end", 1'b1);

    // mode 1 (cpha only), divisor 4
    sif.cpol_i = 1'b0;
    sppr_i     = 3'd1;
    tick();
    sif.ss_i = 1'b0;
    #1;
    run_active("mode1", 6, 2);

    // wait-mode stall and resume
    sif.cpha_i = 1'b0;
    spi_mode_i = 2'b01;
    spiswai_i  = 1'b1;
    #1;
    chk("wait_drop_strobes", {10'd0, sif.sample_pulse_o, sif.shift_pulse_o}, 12'd0);
    tick();
    chk_idle("wait_stall1", 1'b0);
    tick();
    chk_idle("wait_stall2", 1'b0);
    spiswai_i = 1'b0;
    #1;
    run_active("wait_resume", 6, 2);

    // stop mode behaves as ss high
    spi_mode_i = 2'b10;
    tick();
    chk_idle("stop1", 1'b0);
    spi_mode_i = 2'b11;
    tick();
    chk_idle("stop2", 1'b0);
    spi_mode_i = 2'b00;
    #1;
    run_active("run_again", 3, 2);

    // divisor freeze during transfer
    spr_i = 3'd2;
    tick();
    chk("freeze1", BaudRateDivisor_o, 12'd4);
    tick();
    chk("freeze2", BaudRateDivisor_o, 12'd4);
    sif.ss_i = 1'b1;
    tick();
    chk("unfreeze", BaudRateDivisor_o, 12'd16);

    // minimum divisor, cpol 1, then reset mid-stream
    sppr_i     = 3'd0;
    spr_i      = 3'd0;
    sif.cpol_i = 1'b1;
    tick();
    chk("div_min", BaudRateDivisor_o, 12'd2);
    chk_idle("min_idle", 1'b1);
    sif.ss_i = 1'b0;
    #1;
    run_active("min_div", 6, 1);
    PRESET = 1'b1;
    tick();
    chk("rst_mid_div", BaudRateDivisor_o, 12'd2);
    chk_idle("rst_mid", 1'b0);
    PRESET   = 1'b0;
    sif.ss_i = 1'b1;
    tick();
    chk_idle("post_rst_idle", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_baud_generator.md
Name: spi_baud_generator

Overview:
Upstream neighbour of the SPI slave-select generator in the APB SPI master. Turns the prescaler fields (SPPR, SPR) into the 12-bit baud-rate divisor that the slave-select generator consumes. While a transfer is in progress (ss_i low), it produces SCLK with the programmed CPOL. It also produces one-PCLK sample and shift strobes that tell the shift register when to capture MISO and when to drive MOSI.

Parameters:
DIV_W, 12, width of BaudRateDivisor_o and of the internal half-period counter
SPI_RUN, 2'b00, spi_mode_i encoding for run mode
SPI_WAIT, 2'b01, spi_mode_i encoding for wait mode

Ports:
PCLK  input  1  APB clock; the only clock
PRESET  input  1  synchronous reset, active-high
spi_mode_i  input  2  SPI power mode; 00 = run, 01 = wait, others = stop
spiswai_i  input  1  SPISWAI control bit; 1 stops SCLK in wait mode
sppr_i  input  3  baud prescaler selection (SPPR)
spr_i  input  3  baud rate selection (SPR)
cpol_i  input  1  clock polarity; idle level of SCLK
cpha_i  input  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge
ss_i  input  1  slave select from the slave-select generator; active-low
BaudRateDivisor_o  output  12  divisor = (sppr+1) * 2^(spr+1)
sclk_o  output  1  SPI serial clock
sample_pulse_o  output  1  one-PCLK strobe: the next SCLK edge is a sample edge
shift_pulse_o  output  1  one-PCLK strobe: the next SCLK edge is a shift edge

Behaviour:
- Reset and clocking: reset is synchronous and active-high (PRESET sampled on PCLK rising edge). All state updates on PCLK rising edge.
- Reset values:
  - div_r = 12'd2
  - count_r = 0
  - sclk_r = 0
  - sample_pulse_o = 0, shift_pulse_o = 0
- enable = !ss_i && !spiswai_i && (spi_mode_i == SPI_RUN || spi_mode_i == SPI_WAIT). This qualification matches the slave-select generator exactly.
- Divisor capture:
  - When enable = 0: div_r <= (sppr_i + 1) << (spr_i + 1). Computed at 12 bits; range 2..2048, so no overflow. One-cycle latency.
  - When enable = 1: div_r holds. Mid-transfer prescaler writes take effect only after ss_i rises.
- BaudRateDivisor_o = div_r.
- Half-period: half = div_r >> 1. Minimum value is 1.
- Inactive cycle (enable = 0): count_r <= 0 and sclk_r <= cpol_i. A CPOL change is reflected on sclk_o one cycle later.
- Active cycle (enable = 1):
  - If count_r == half - 1: count_r <= 0 and sclk_r <= ~sclk_r.
  - Otherwise: count_r <= count_r + 1.
- sclk_o = sclk_r, driven directly from the register with no combinational path. The first edge occurs half PCLKs after enable rises.
- Edge strobes:
  - edge_next = enable && (count_r == half - 1), i.e. the last PCLK before an SCLK toggle.
  - leading = (sclk_r == cpol_i).
  - sample_pulse_o = edge_next && (leading ^ cpha_i).
  - shift_pulse_o = edge_next && !(leading ^ cpha_i).
  - Decoded from registered state; never both high at once.
- Divisor 2 (half = 1): edge_next is high every active cycle, and SCLK toggles every PCLK.
- Deassertion: if ss_i rises or the mode leaves run/wait mid-period, the next cycle forces count_r = 0 and sclk_r = cpol_i, and strobes drop immediately. No partial-edge glitch beyond returning to idle.
- Reset asserted mid-transfer: all state returns to reset values on the next PCLK edge. sclk_r stays 0 until the first inactive cycle loads cpol_i.
- Stop mode (spi_mode_i = 2'b10 or 2'b11) behaves identically to ss_i = 1.

Decomposition:
- Shared package spi_pkg holds the SPI_RUN, SPI_WAIT and SPI_STOP encodings and DIV_W. The slave-select generator and the shift register use the same package.
- Single flat module; no sub-module needed. The divisor computation is one shift-multiply expression.

Test Plan:
- Divisor: sppr = 3'd1, spr = 3'd0, ss_i = 1 -> BaudRateDivisor_o = 4 one cycle later. sppr = 7, spr = 7 -> 2048.
- SCLK, mode 0: divisor 4, cpol = 0, cpha = 0, ss_i falls -> sclk_o rises at PCLK 2, falls at 4, rises at 6. sample_pulse_o high at cycles 1, 5; shift_pulse_o high at cycle 3.
- SCLK, mode 3: cpol = 1, cpha = 1, divisor 8 -> sclk_o idles 1, first edge (falling) after 4 PCLKs. shift_pulse_o precedes the falling edge, sample_pulse_o precedes the rising edge.
- Wait stall: spi_mode_i = 01, spiswai_i = 1 during a transfer -> next cycle sclk_o = cpol_i, count_r = 0, no strobes. With spiswai_i = 0 -> resumes toggling.
- Divisor freeze: change spr_i from 0 to 2 while ss_i = 0 -> BaudRateDivisor_o stays 4. After ss_i = 1 -> becomes 16 one cycle later.
- Minimum divisor and reset: divisor 2 -> sclk_o toggles every PCLK with alternating strobes. Assert PRESET mid-stream -> next edge shows div_r = 2, sclk_o = 0, both strobes = 0.
